// File: rtl/pkt_egress_buffer.sv
// pkt_egress_buffer: store-and-forward packet buffer for one DUT output port.
// Beat-serial packets (valid/sop/eop, no backpressure) are written into a
// circular buffer; only fully received packets are released to a
// show-ahead ready/valid consumer. Packets that overflow or lose their eop
// are rolled back so committed packets are never disturbed.
//
// Optional build macro: PKT_EGRESS_STATS_EN
//   defined     -> pkt_cnt / drop_cnt are saturating 16-bit counters
//   not defined -> no counter flops, both outputs tied to 16'h0
//
// Input side (no backpressure): a beat is taken on any rising edge with
// in_valid=1; in_sop/in_eop are only meaningful with in_valid.
// Output side: a beat transfers on a rising edge with out_valid&out_ready;
// out_valid/out_sop/out_eop/out_data stay stable while out_valid&~out_ready.
module pkt_egress_buffer #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sop,
  output logic          out_eop,
  output logic [DW-1:0] out_data,
  output logic [15:0]   pkt_cnt,
  output logic [15:0]   drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  // IDLE: between packets; RECV: writing a packet; DROP: discarding the
  // remainder of a packet that was abandoned because of overflow.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] wr_ptr, wr_nxt;
  logic [PW-1:0] commit_ptr, commit_nxt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] pkt_start, start_nxt;

  // Each entry holds {sop, eop, data}.
  logic [DW+1:0] mem [DEPTH];
  logic [DW+1:0] head;

  logic          full;
  logic          pop;
  logic          wr_en;
  logic [PW-1:0] wr_addr;
  logic [PW-1:0] base;
  logic          base_full;
  logic          pkt_inc;
  logic          drop_inc;

  // Occupancy counts every written beat, committed or not; a pop in the
  // same cycle does not free space for the arriving beat.
  assign full = ((wr_ptr - rd_ptr) == DEPTH_P);
  assign pop  = out_valid & out_ready;

  // Next-state, write and counter-event decode for the input side.
  always_comb begin
    state_nxt  = state;
    wr_nxt     = wr_ptr;
    commit_nxt = commit_ptr;
    start_nxt  = pkt_start;
    wr_en      = 1'b0;
    wr_addr    = wr_ptr;
    pkt_inc    = 1'b0;
    drop_inc   = 1'b0;
    // A sop in RECV abandons the open packet, so the new packet starts at
    // the rolled-back position; otherwise it starts at the write pointer.
    base       = (state == RECV) ? pkt_start : wr_ptr;
    base_full  = ((base - rd_ptr) == DEPTH_P);
    if (in_valid) begin
      if (in_sop) begin
        if (state == RECV) begin
          drop_inc = 1'b1;
        end
        if (base_full) begin
          drop_inc  = 1'b1;
          wr_nxt    = base;
          state_nxt = in_eop ? IDLE : DROP;
        end else begin
          wr_en     = 1'b1;
          wr_addr   = base;
          start_nxt = base;
          wr_nxt    = base + ONE_P;
          if (in_eop) begin
            commit_nxt = base + ONE_P;
            pkt_inc    = 1'b1;
            state_nxt  = IDLE;
          end else begin
            state_nxt  = RECV;
          end
        end
      end else if (state == RECV) begin
        if (full) begin
          drop_inc  = 1'b1;
          wr_nxt    = pkt_start;
          state_nxt = in_eop ? IDLE : DROP;
        end else begin
          wr_en   = 1'b1;
          wr_addr = wr_ptr;
          wr_nxt  = wr_ptr + ONE_P;
          if (in_eop) begin
            commit_nxt = wr_ptr + ONE_P;
            pkt_inc    = 1'b1;
            state_nxt  = IDLE;
          end
        end
      end else if ((state == DROP) && in_eop) begin
        state_nxt = IDLE;
      end
    end
  end

  // FSM state and pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      pkt_start  <= '0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_nxt;
      commit_ptr <= commit_nxt;
      pkt_start  <= start_nxt;
      if (pop) begin
        rd_ptr <= rd_ptr + ONE_P;
      end
    end
  end

  // Beat storage; contents are only observed through committed pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[AW-1:0]] <= {in_sop, in_eop, in_data};
    end
  end

  // Show-ahead read of the head entry, forced to zero when nothing is committed.
  always_comb begin
    head      = mem[rd_ptr[AW-1:0]];
    out_valid = (rd_ptr != commit_ptr);
    out_sop   = out_valid & head[DW+1];
    out_eop   = out_valid & head[DW];
    out_data  = out_valid ? head[DW-1:0] : '0;
  end

`ifdef PKT_EGRESS_STATS_EN
  logic [15:0] pkt_q;
  logic [15:0] drop_q;

  // Saturating committed/dropped packet counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      if (pkt_inc && (pkt_q != 16'hFFFF)) begin
        pkt_q <= pkt_q + 16'd1;
      end
      if (drop_inc && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign pkt_cnt  = pkt_q;
  assign drop_cnt = drop_q;
`else
  logic unused_stats;
  assign unused_stats = pkt_inc ^ drop_inc;
  assign pkt_cnt      = 16'h0;
  assign drop_cnt     = 16'h0;
`endif

endmodule

// File: tb/tb_pkt_egress_buffer.sv
// Bench for pkt_egress_buffer: directed scenarios plus randomized traffic,
// compared every cycle against a packet-level queue model.
module tb_pkt_egress_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  typedef logic [DW+1:0] beat_t;

  // clock / reset block
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_sop;
  logic          out_eop;
  logic [DW-1:0] out_data;
  logic [15:0]   pkt_cnt;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  pkt_egress_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_data  (out_data),
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt)
  );

  // scoreboard: committed beats awaiting delivery, open packet, delivered log
  logic [DW+1:0] exp_q[$];
  beat_t         pend_q[$];
  beat_t         got_q[$];
  int            m_mode;   // 0 between packets, 1 collecting, 2 discarding
  int            m_pkts;
  int            m_drops;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] cnt_val(input int n);
`ifdef PKT_EGRESS_STATS_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return 16'h0;
`endif
  endfunction

  function automatic void model_commit();
    foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
    pend_q.delete();
    m_pkts++;
    m_mode = 0;
  endfunction

  // Packet-level rules: space is all stored beats, committed or pending.
  function automatic void model_beat(input logic v, input logic sop, input logic eop,
                                     input logic [DW-1:0] data);
    bit full;
    if (!v) return;
    if (m_mode == 1 && sop) begin
      m_drops++;
      pend_q.delete();
      m_mode = 0;
    end
    full = (exp_q.size() + pend_q.size()) >= DEPTH;
    if (sop) begin
      if (full) begin
        m_drops++;
        m_mode = eop ? 0 : 2;
      end else begin
        pend_q.push_back({1'b1, eop, data});
        if (eop) model_commit();
        else m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (full) begin
        m_drops++;
        pend_q.delete();
        m_mode = eop ? 0 : 2;
      end else begin
        pend_q.push_back({1'b0, eop, data});
        if (eop) model_commit();
      end
    end else if (m_mode == 2 && eop) begin
      m_mode = 0;
    end
  endfunction

  // The single compare point: DUT outputs against the model after each edge.
  task automatic compare_outputs();
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("out_sop", out_sop, exp_q[0][DW+1]);
      check("out_eop", out_eop, exp_q[0][DW]);
      check("out_data", out_data, exp_q[0][DW-1:0]);
    end
    check("pkt_cnt", pkt_cnt, cnt_val(m_pkts));
    check("drop_cnt", drop_cnt, cnt_val(m_drops));
  endtask

  // driver tasks
  task automatic cycle(input logic v, input logic sop, input logic eop,
                       input logic [DW-1:0] data, input logic rdy);
    bit model_pop;
    @(negedge clk);
    compare_outputs();
    in_valid  = v;
    in_sop    = sop;
    in_eop    = eop;
    in_data   = data;
    out_ready = rdy;
    if (out_valid && rdy) got_q.push_back({out_sop, out_eop, out_data});
    model_pop = (exp_q.size() != 0) && rdy;
    model_beat(v, sop, eop, data);
    if (model_pop) void'(exp_q.pop_front());
  endtask

  task automatic send_pkt(input int len, input logic [DW-1:0] base, input logic rdy);
    for (int i = 0; i < len; i++)
      cycle(1'b1, i == 0, i == len - 1, base + DW'(i), rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("drain_idle", out_valid, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sop", out_sop, 1'b0);
    check("rst_out_eop", out_eop, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_pkt_cnt", pkt_cnt, 16'h0);
    check("rst_drop_cnt", drop_cnt, 16'h0);
    exp_q.delete();
    pend_q.delete();
    got_q.delete();
    m_mode  = 0;
    m_pkts  = 0;
    m_drops = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    beat_t exp_b;
    int    rdy_pct;
    logic  v, s, e;

    // 1: reset in the middle of a packet
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 8'h55, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'h66, 1'b1);
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("t1_out_valid", out_valid, 1'b0);

    // 2: one 4-beat packet with the consumer always ready
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 8'h11, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'h22, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'h33, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 8'h44, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("t2_valid_after_eop", out_valid, 1'b1);
    check("t2_first_beat", {out_sop, out_eop, out_data}, 10'h211);
    drain();
    check("t2_beats", got_q.size(), 4);
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      case (i)
        0: exp_b = 10'h211;
        1: exp_b = 10'h022;
        2: exp_b = 10'h033;
        default: exp_b = 10'h144;
      endcase
      check("t2_beat", got_q[i], exp_b);
    end
    check("t2_pkt_cnt", pkt_cnt, cnt_val(1));

    // 3: packet longer than the buffer, then a short one
    do_reset();
    send_pkt(20, 8'h40, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("t3_drop_cnt", drop_cnt, cnt_val(1));
    check("t3_out_valid", out_valid, 1'b0);
    send_pkt(3, 8'hC0, 1'b0);
    drain();
    check("t3_beats", got_q.size(), 3);
    if (got_q.size() == 3) check("t3_last_beat", got_q[2], 10'h1C2);
    check("t3_pkt_cnt", pkt_cnt, cnt_val(1));

    // 4: 12 committed beats, then a 6-beat packet overflows at its 5th beat
    do_reset();
    for (int k = 0; k < 3; k++) send_pkt(4, DW'(1 + 4 * k), 1'b0);
    send_pkt(6, 8'h80, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("t4_drop_cnt", drop_cnt, cnt_val(1));
    check("t4_pkt_cnt", pkt_cnt, cnt_val(3));
    drain();
    check("t4_beats", got_q.size(), 12);
    for (int i = 0; i < got_q.size() && i < 12; i++)
      check("t4_beat_data", got_q[i][DW-1:0], 32'(i + 1));

    // 5: second sop before eop abandons the first packet
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 8'hA0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'hA1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 8'hA2, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 8'hA3, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 8'hA4, 1'b1);
    drain();
    check("t5_beats", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("t5_beat0", got_q[0], 10'h2A2);
      check("t5_beat1", got_q[1], 10'h0A3);
      check("t5_beat2", got_q[2], 10'h1A4);
    end
    check("t5_drop_cnt", drop_cnt, cnt_val(1));
    check("t5_pkt_cnt", pkt_cnt, cnt_val(1));

    // 6: 100 single-beat packets with the consumer toggling
    do_reset();
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 1'b1, 1'b1, DW'(i), 1'b1);
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    end
    drain();
    check("t6_beats", got_q.size(), 100);
    for (int i = 0; i < got_q.size() && i < 100; i++)
      check("t6_beat", got_q[i], {2'b11, 8'(i)});
    check("t6_pkt_cnt", pkt_cnt, cnt_val(100));
    check("t6_drop_cnt", drop_cnt, cnt_val(0));

    // randomized traffic with varying consumer throughput
    do_reset();
    rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rdy_pct = $urandom_range(5, 95);
      v = ($urandom_range(0, 99) < 75);
      s = ($urandom_range(0, 99) < 15);
      e = ($urandom_range(0, 99) < 14);
      cycle(v, s, e, DW'($urandom), $urandom_range(0, 99) < rdy_pct);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
